// File: rtl/mod_m_prog_counter.sv
// mod_m_prog_counter: programmable modulo up/down counter, free-running or one-shot, with load, tick, wrap, done and busy.
//   Ports: clk, reset (sync, active-high); en, up, mode, start, load, load_val[W], mod_val[W];
//          count[W] (registered), tick (comb), wrap/busy/done (registered).
module mod_m_prog_counter #(
  parameter int W = 8,
  parameter longint M = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         up,
  input  logic         mode,
  input  logic         start,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] mod_val,
  output logic [W-1:0] count,
  output logic         tick,
  output logic         wrap,
  output logic         busy,
  output logic         done
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t state;
  logic [W-1:0] mod_reg, lim, rst_val;
  logic [W:0] mod_eff, mod_nxt;
  logic step;
  assign busy = state == S_RUN;
  // mod_nxt is the modulus that takes effect at this edge's boundary, so the
  // restart value and the load clamp are taken from it rather than mod_reg.
  always_comb begin
    mod_eff = mod_reg == '0 ? (W+1)'(M) : {1'b0, mod_reg};
    mod_nxt = mod_val == '0 ? (W+1)'(M) : {1'b0, mod_val};
    lim = W'(mod_nxt - (W+1)'(1));
    rst_val = up ? '0 : lim;
    step = en & busy & ~load;
    tick = step & ({1'b0, count} == (up ? mod_eff - (W+1)'(1) : '0));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      mod_reg <= W'(M);
      wrap <= 1'b0;
      done <= 1'b0;
      state <= mode ? S_IDLE : S_RUN;
    end else if (load) begin
      mod_reg <= mod_val;
      count <= load_val > lim ? lim : load_val;
      wrap <= 1'b0;
      done <= 1'b0;
    end else begin
      wrap <= tick;
      done <= tick & mode;
      case (state)
        S_IDLE:
          if (!mode) state <= S_RUN;
          else if (start) begin
            state <= S_RUN;
            count <= rst_val;
            mod_reg <= mod_val;
          end
        S_RUN:
          if (tick) begin
            count <= rst_val;
            mod_reg <= mod_val;
            if (mode) state <= S_DONE;
          end else if (step) count <= up ? count + 1'b1 : count - 1'b1;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mod_m_prog_counter.sv
// tb_mod_m_prog_counter: directed and random checks of mod_m_prog_counter against a behavioural model.
module tb_mod_m_prog_counter;
  localparam int W = 8;
  localparam int M = 10;
  logic clk = 1'b0;
  logic reset, en, up, mode, start, load;
  logic [W-1:0] load_val, mod_val, count;
  logic tick, wrap, busy, done;
  int n_chk = 0, n_pass = 0;
  int m_cnt, m_mreg;
  bit m_wrap, m_done, m_busy, m_post, m_valid = 0;
  int s_cnt;
  bit s_tick, s_wrap, s_busy, s_done;
  always #5 clk = ~clk;
  mod_m_prog_counter #(.W(W), .M(M)) dut (
    .clk(clk), .reset(reset), .en(en), .up(up), .mode(mode), .start(start),
    .load(load), .load_val(load_val), .mod_val(mod_val), .count(count),
    .tick(tick), .wrap(wrap), .busy(busy), .done(done)
  );
  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
  endtask
  // One clock: drive at negedge, sample and compare, then advance the model at posedge.
  task automatic cyc(input bit r, input bit e, input bit u, input bit md, input bit s,
                     input bit l, input int lv, input int mv);
    int meff, mnxt, et;
    bit stp;
    @(negedge clk);
    reset = r; en = e; up = u; mode = md; start = s; load = l;
    load_val = W'(lv); mod_val = W'(mv);
    #1;
    s_cnt = int'(count); s_tick = tick; s_wrap = wrap; s_busy = busy; s_done = done;
    meff = m_mreg == 0 ? M : m_mreg;
    mnxt = mv == 0 ? M : mv;
    stp = e && m_busy && !l;
    et = (stp && m_cnt == (u ? meff - 1 : 0)) ? 1 : 0;
    if (m_valid) begin
      chk("count", s_cnt, m_cnt);
      chk("tick", int'(s_tick), et);
      chk("wrap", int'(s_wrap), int'(m_wrap));
      chk("busy", int'(s_busy), int'(m_busy));
      chk("done", int'(s_done), int'(m_done));
    end
    @(posedge clk);
    if (r) begin
      m_cnt = 0; m_mreg = M; m_wrap = 0; m_done = 0;
      m_busy = !md; m_post = 0; m_valid = 1;
    end else if (l) begin
      m_mreg = mv;
      m_cnt = lv < mnxt - 1 ? lv : mnxt - 1;
      m_wrap = 0; m_done = 0;
    end else begin
      m_wrap = et != 0;
      m_done = et != 0 && md;
      if (m_post) m_post = 0;
      else if (!m_busy) begin
        if (!md) m_busy = 1;
        else if (s) begin
          m_busy = 1; m_cnt = u ? 0 : mnxt - 1; m_mreg = mv;
        end
      end else if (et != 0) begin
        m_cnt = u ? 0 : mnxt - 1; m_mreg = mv;
        if (md) begin m_busy = 0; m_post = 1; end
      end else if (stp) m_cnt = u ? m_cnt + 1 : m_cnt - 1;
    end
  endtask
  initial begin
    int nt, nw, nd, sum, mx, mv, lv;
    bit md, u;
    // Free-running up, default modulus.
    cyc(1, 0, 1, 0, 0, 0, 0, 0);
    nt = 0; nw = 0;
    for (int i = 0; i < 25; i++) begin
      cyc(0, 1, 1, 0, 0, 0, 0, 0);
      if (i == 0) begin chk("lit_first_count", s_cnt, 0); chk("lit_busy_free", int'(s_busy), 1); end
      if (i == 9) chk("lit_count9", s_cnt, 9);
      nt += int'(s_tick); nw += int'(s_wrap);
    end
    chk("lit_up_ticks", nt, 2);
    chk("lit_up_wraps", nw, 2);
    chk("lit_up_last", s_cnt, 4);
    // Free-running down.
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    nt = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(0, 1, 0, 0, 0, 0, 0, 0);
      if (i == 0) chk("lit_down_first_tick", int'(s_tick), 1);
      if (i == 1) chk("lit_down_second", s_cnt, 9);
      nt += int'(s_tick);
    end
    chk("lit_down_ticks", nt, 2);
    chk("lit_down_last", s_cnt, 9);
    // One-shot, modulus 5.
    cyc(1, 0, 1, 1, 0, 0, 0, 0);
    cyc(0, 1, 1, 1, 1, 0, 0, 5);
    chk("lit_os_idle_busy", int'(s_busy), 0);
    sum = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 1, 1, 0, 0, 0, 5);
      chk("lit_os_busy", int'(s_busy), 1);
      sum += s_cnt;
    end
    chk("lit_os_sum", sum, 10);
    chk("lit_os_tick", int'(s_tick), 1);
    cyc(0, 1, 1, 1, 0, 0, 0, 5);
    chk("lit_os_done", int'(s_done), 1);
    chk("lit_os_busy_off", int'(s_busy), 0);
    nt = 0; nd = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 1, 1, 0, 0, 0, 5);
      nt += int'(s_tick); nd += int'(s_done);
    end
    chk("lit_os_quiet_ticks", nt, 0);
    chk("lit_os_quiet_done", nd, 0);
    chk("lit_os_hold", s_cnt, 0);
    // Load clamped to the newly captured modulus.
    cyc(1, 0, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 1, 200, 16);
    cyc(0, 1, 1, 0, 0, 0, 0, 16);
    chk("lit_load_clamp", s_cnt, 15);
    chk("lit_load_tick", int'(s_tick), 1);
    cyc(0, 1, 1, 0, 0, 0, 0, 16);
    chk("lit_load_wrap_cnt", s_cnt, 0);
    chk("lit_load_wrap", int'(s_wrap), 1);
    // Modulus change mid-period only applies at the next wrap.
    cyc(1, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0, 0, 4);
    chk("lit_mc_at3", s_cnt, 3);
    for (int i = 0; i < 6; i++) cyc(0, 1, 1, 0, 0, 0, 0, 4);
    chk("lit_mc_reach9", s_cnt, 9);
    mx = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 1, 0, 0, 0, 0, 4);
      if (s_cnt > mx) mx = s_cnt;
    end
    chk("lit_mc_max", mx, 3);
    // Reset beats everything.
    cyc(0, 1, 1, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 1, 1, 7, 3);
    cyc(0, 1, 1, 0, 0, 0, 0, 0);
    chk("lit_rst_cnt", s_cnt, 0);
    chk("lit_rst_wrap", int'(s_wrap), 0);
    chk("lit_rst_done", int'(s_done), 0);
    cyc(0, 1, 1, 0, 0, 0, 0, 0);
    chk("lit_rst_resume", s_cnt, 1);
    // Random traffic against the model.
    md = 0; u = 1; mv = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(29) == 0) md = ~md;
      if ($urandom_range(9) == 0) u = ~u;
      if ($urandom_range(6) == 0)
        case ($urandom_range(3))
          0: mv = 0;
          1: mv = int'($urandom_range(1, 3));
          2: mv = int'($urandom_range(4, 20));
          default: mv = int'($urandom_range(255));
        endcase
      lv = int'($urandom_range(255));
      cyc($urandom_range(199) == 0, $urandom_range(4) != 0, u, md,
          $urandom_range(7) == 0, $urandom_range(39) == 0, lv, mv);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
